// File: rtl/vga_player_pkg.sv
// Shared definitions for the VGA player datapath.
// Holds the instruction field layout, the end-of-frame marker and the
// encoding of the pixel scheduler FSM states.
package vga_player_pkg;

    localparam int RUN_W   = 12;
    localparam int COLOR_W = 6;
    localparam int INSTR_W = RUN_W + COLOR_W;

    // Field slices of an instruction word: {colour, run}
    localparam int COLOR_MSB = INSTR_W - 1;
    localparam int COLOR_LSB = RUN_W;
    localparam int RUN_MSB   = RUN_W - 1;
    localparam int RUN_LSB   = 0;

    localparam logic [INSTR_W-1:0] EOF_MARKER = 18'h3FFFF;

    // Pixel FSM state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_EOF_WAIT = 2'd3;

    function automatic logic is_eof(input logic [INSTR_W-1:0] word);
        return word == EOF_MARKER;
    endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry register FIFO for flash instructions.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (count only)
//   push, pop    write din / retire dout; both together is legal at any count
//   din, dout    write data / head of the queue (valid when count != 0)
//   count        number of stored entries, 0..2
// The caller must not push when full without also popping, and must not
// pop when empty.
module instr_fifo2 #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0_q, mem0_d;   // head entry
    logic [WIDTH-1:0] mem1_q, mem1_d;   // second entry
    logic [1:0]       count_q, count_d;

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) mem0_d = din;
                else                 mem1_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                mem0_d  = mem1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever remains.
                if (count_q == 2'd2) begin
                    mem0_d = mem1_q;
                    mem1_d = din;
                end else begin
                    mem0_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= 2'd0;
        else        count_q <= count_d;
    end

    // Storage carries no reset; count alone defines what is valid.
    always_ff @(posedge clk) begin
        mem0_q <= mem0_d;
        mem1_q <= mem1_d;
    end

    assign dout  = mem0_q;
    assign count = count_q;

endmodule

// File: rtl/rle_pixel_scheduler.sv
// Run-length pixel scheduler between the QSPI flash reader and VGA output.
// Captures one instruction per rising edge of instr_valid into a 2-entry
// FIFO, paces the reader with shift_data, and expands each {colour, run}
// instruction into run+1 pixels consumed by pixel_en. An all-ones word is
// the end-of-frame marker; the FSM then waits for frame_start.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   instr          {colour[17:12], run[11:0]} from the flash reader
//   instr_valid    reader valid (pulse, or held high while waiting)
//   shift_data     registered request for the next instruction
//   frame_start    first active pixel slot of a frame
//   pixel_en       VGA stage consumes a pixel this cycle
//   pixel_rgb      registered colour of the current pixel
//   underrun, overflow, sync_err   sticky error flags
module rle_pixel_scheduler
    import vga_player_pkg::*;
#(
    parameter int RUN_W   = vga_player_pkg::RUN_W,
    parameter int COLOR_W = vga_player_pkg::COLOR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RUN_W+COLOR_W-1:0] instr,
    input  logic                     instr_valid,
    output logic                     shift_data,
    input  logic                     frame_start,
    input  logic                     pixel_en,
    output logic [COLOR_W-1:0]       pixel_rgb,
    output logic                     underrun,
    output logic                     overflow,
    output logic                     sync_err
);

    localparam int W = RUN_W + COLOR_W;

    logic             valid_q;
    logic [1:0]       state_q, state_d;
    logic [COLOR_W-1:0] cur_color_q, cur_color_d;
    logic [RUN_W-1:0] remaining_q, remaining_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic             shift_q, shift_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic             sync_err_q, sync_err_d;

    logic             capture;
    logic             push, pop, do_load, eof_pop;
    logic [W-1:0]     head;
    logic [1:0]       count;
    logic             fifo_empty, fifo_full;

    instr_fifo2 #(.WIDTH(W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (instr),
        .dout  (head),
        .count (count)
    );

    // A held-high valid is a single word: only its rising edge captures.
    assign capture    = instr_valid && !valid_q;
    assign fifo_empty = (count == 2'd0);
    assign fifo_full  = (count == 2'd2);

    always_comb begin
        state_d     = state_q;
        cur_color_d = cur_color_q;
        remaining_d = remaining_q;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        sync_err_d  = sync_err_q;
        do_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!fifo_empty)   do_load    = 1'b1;
                else if (pixel_en) underrun_d = 1'b1;   // pixel is lost as black
            end
            ST_RUN: begin
                if (pixel_en) begin
                    if (remaining_q != '0)  remaining_d = remaining_q - 1'b1;
                    else if (!fifo_empty)   do_load     = 1'b1;   // no bubble between runs
                    else                    state_d     = ST_LOAD;
                end
            end
            default: begin  // ST_EOF_WAIT
                if (frame_start) state_d = ST_LOAD;
            end
        endcase

        eof_pop = do_load && is_eof(head);
        if (do_load) begin
            if (is_eof(head)) begin
                // A frame_start coinciding with the marker is the expected alignment.
                state_d = frame_start ? ST_LOAD : ST_EOF_WAIT;
            end else begin
                state_d     = ST_RUN;
                cur_color_d = head[W-1:RUN_W];
                remaining_d = head[RUN_W-1:0];
            end
        end
        pop = do_load;

        // Out-of-place frame_start is only flagged; resync waits for the marker.
        if (frame_start && (state_q == ST_LOAD || state_q == ST_RUN) && !eof_pop)
            sync_err_d = 1'b1;

        // A push into a full FIFO is accepted only if a pop frees a slot now.
        push = capture && (!fifo_full || pop);
        if (capture && fifo_full && !pop) overflow_d = 1'b1;

        shift_d = (count == 2'd0) || (count == 2'd1 && !capture);
        rgb_d   = (state_d == ST_RUN) ? cur_color_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            state_q    <= ST_IDLE;
            rgb_q      <= '0;
            shift_q    <= 1'b1;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            valid_q    <= instr_valid;
            state_q    <= state_d;
            rgb_q      <= rgb_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Run state is only meaningful in RUN, so it needs no reset.
    always_ff @(posedge clk) begin
        cur_color_q <= cur_color_d;
        remaining_q <= remaining_d;
    end

    assign shift_data = shift_q;
    assign pixel_rgb  = rgb_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_rle_pixel_scheduler.sv
module tb_rle_pixel_scheduler;
    import vga_player_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] instr;
    logic        instr_valid;
    logic        shift_data;
    logic        frame_start;
    logic        pixel_en;
    logic [5:0]  pixel_rgb;
    logic        underrun;
    logic        overflow;
    logic        sync_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rle_pixel_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .shift_data  (shift_data),
        .frame_start (frame_start),
        .pixel_en    (pixel_en),
        .pixel_rgb   (pixel_rgb),
        .underrun    (underrun),
        .overflow    (overflow),
        .sync_err    (sync_err)
    );

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [17:0] instr;
        logic        fs;
        logic        pe;
        logic        e_shift;
        logic [5:0]  e_rgb;
        logic        e_und;
        logic        e_ovf;
        logic        e_sync;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic [17:0] in,
                                input logic fs, input logic pe, input logic es,
                                input logic [5:0] ergb, input logic eu, input logic eo,
                                input logic esy);
        vec_t v;
        v.rst_n = r;  v.iv = iv; v.instr = in; v.fs = fs; v.pe = pe;
        v.e_shift = es; v.e_rgb = ergb; v.e_und = eu; v.e_ovf = eo; v.e_sync = esy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then compare outputs just after the edge.
    task automatic step(input string tag, input vec_t v);
        rst_n       = v.rst_n;
        instr_valid = v.iv;
        instr       = v.instr;
        frame_start = v.fs;
        pixel_en    = v.pe;
        @(posedge clk);
        #1;
        chk({tag, ".shift"},    {17'd0, shift_data}, {17'd0, v.e_shift});
        chk({tag, ".rgb"},      {12'd0, pixel_rgb},  {12'd0, v.e_rgb});
        chk({tag, ".underrun"}, {17'd0, underrun},   {17'd0, v.e_und});
        chk({tag, ".overflow"}, {17'd0, overflow},   {17'd0, v.e_ovf});
        chk({tag, ".sync_err"}, {17'd0, sync_err},   {17'd0, v.e_sync});
    endtask

    localparam logic [17:0] EOFW = 18'h3FFFF;
    localparam logic [17:0] Z    = 18'h0;

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; frame_start = 1'b0; pixel_en = 1'b0;
        #1;

        // Back-to-back runs, EOF handling, mid-run frame_start, underrun.
        //                rst iv instr               fs pe  shf rgb    und ovf syn
        tbl.push_back(mk(0, 0, Z,                  0, 0,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, Z,                  0, 0,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, {6'h30, 12'd2},     0, 0,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 0,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, {6'h0C, 12'd0},     0, 0,  0, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  1, 0,  0, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 0,  0, 6'h30, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h30, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h30, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h0C, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, EOFW,               0, 0,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 0,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, {6'h15, 12'd1},     0, 1,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  1, 0,  1, 6'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  0, 0,  1, 6'h15, 0, 0, 0));
        tbl.push_back(mk(1, 0, Z,                  1, 1,  1, 6'h15, 0, 0, 1));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, Z,                  0, 1,  1, 6'h00, 1, 0, 1));
        tbl.push_back(mk(1, 1, {6'h2A, 12'd0},     0, 0,  1, 6'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, Z,                  0, 0,  1, 6'h2A, 1, 0, 1));

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl%0d", i), tbl[i]);

        // Held valid, pacing and overflow with FIFO contents preserved.
        step("b_rst0", mk(0, 0, Z, 0, 0, 1, 6'h00, 0, 0, 0));
        step("b_rst1", mk(0, 0, Z, 0, 0, 1, 6'h00, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            step($sformatf("b_hold%0d", i), mk(1, 1, {6'h11, 12'd0}, 0, 0, 1, 6'h00, 0, 0, 0));
        step("b_one",    mk(1, 0, Z,              0, 0, 1, 6'h00, 0, 0, 0));
        step("b_full",   mk(1, 1, {6'h22, 12'd0}, 0, 0, 0, 6'h00, 0, 0, 0));
        step("b_gap",    mk(1, 0, Z,              0, 0, 0, 6'h00, 0, 0, 0));
        step("b_ovf",    mk(1, 1, {6'h3F, 12'd5}, 0, 0, 0, 6'h00, 0, 1, 0));
        step("b_fs",     mk(1, 0, Z,              1, 0, 0, 6'h00, 0, 1, 0));
        step("b_pop1",   mk(1, 0, Z,              0, 0, 0, 6'h11, 0, 1, 0));
        step("b_shift1", mk(1, 0, Z,              0, 0, 1, 6'h11, 0, 1, 0));
        step("b_pop2",   mk(1, 0, Z,              0, 1, 1, 6'h22, 0, 1, 0));
        step("b_drain",  mk(1, 0, Z,              0, 1, 1, 6'h00, 0, 1, 0));
        step("b_midrst", mk(0, 0, Z,              0, 0, 1, 6'h00, 0, 0, 0));

        // frame_start coinciding with the EOF pop realigns without an error.
        step("c_rst",  mk(0, 0, Z,              0, 0, 1, 6'h00, 0, 0, 0));
        step("c_eof",  mk(1, 1, EOFW,           0, 0, 1, 6'h00, 0, 0, 0));
        step("c_fs0",  mk(1, 0, Z,              1, 0, 1, 6'h00, 0, 0, 0));
        chk("c_state_load", {16'd0, dut.state_q}, {16'd0, ST_LOAD});
        step("c_fs1",  mk(1, 0, Z,              1, 0, 1, 6'h00, 0, 0, 0));
        chk("c_state_realign", {16'd0, dut.state_q}, {16'd0, ST_LOAD});
        step("c_push", mk(1, 1, {6'h07, 12'd0}, 0, 0, 1, 6'h00, 0, 0, 0));
        step("c_run",  mk(1, 0, Z,              0, 0, 1, 6'h07, 0, 0, 0));
        step("c_sync", mk(1, 0, Z,              1, 0, 1, 6'h07, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rle_pixel_scheduler.md
# rle_pixel_scheduler

Consumes the 18-bit instruction stream from the QSPI flash reader and schedules it onto the VGA pixel path. Each instruction is one run-length pixel run. The block paces the flash reader through `shift_data`, buffers up to two instructions, and expands each run into per-pixel colour for the VGA output stage. It also aligns the stream to frames with an end-of-frame marker, and reports underrun, overflow and sync errors.

## Interface
Parameters:
- `RUN_W`, default 12: width of the run-length field.
- `COLOR_W`, default 6: colour width (RGB222). `RUN_W + COLOR_W` must equal 18.

Ports:
- `clk`  in  1: system clock. Same clock as the flash reader.
- `rst_n`  in  1: reset, synchronous, active-low.
- `instr`  in  18: instruction from the flash reader. Bits [17:12] are colour, bits [11:0] are run.
- `instr_valid`  in  1: valid from the flash reader. A pulse when streaming; held high while the reader waits.
- `shift_data`  out  1: request to the flash reader to fetch the next instruction.
- `frame_start`  in  1: one-cycle pulse on the first active pixel slot of a frame, from the VGA controller.
- `pixel_en`  in  1: the VGA stage consumes one pixel this cycle (active area only).
- `pixel_rgb`  out  6: colour of the current pixel.
- `underrun`  out  1: sticky flag.
- `overflow`  out  1: sticky flag.
- `sync_err`  out  1: sticky flag.

## Operation
- **Capture:** an instruction is written on `instr_valid && !valid_q`, i.e. the rising edge of `instr_valid`. `valid_q` is `instr_valid` registered.
  - A held-high `instr_valid` counts as one word.
  - A capture when the FIFO is full drops the word and sets `overflow`.
- **FIFO:** 2 entries, first in first out. Count is 0..2.
  - Push and pop in the same cycle are legal at any count, including full.
- **Pacing (`shift_data`), registered:**
  - 1 when count == 0.
  - 1 when count == 1 and no capture this cycle.
  - 0 otherwise.
- **Decode:**
  - Colour is `instr[17:12]`. Pixels in the run = `instr[11:0] + 1`, so the range is 1..4096.
  - `instr == 18'h3FFFF` is the EOF marker. It carries no pixels.
- **Pixel FSM states:**
  - **IDLE:** entered on reset. `pixel_rgb` = 0. Ignores `pixel_en`. On `frame_start` → LOAD.
  - **LOAD:** if the FIFO is not empty, pop it.
    - EOF marker → EOF_WAIT.
    - Otherwise set `cur_color` = colour, set `remaining` = run field, → RUN.
    - If the FIFO is empty, stay in LOAD.
  - **RUN:** `pixel_rgb` = `cur_color`. On `pixel_en`:
    - If `remaining` ≠ 0, decrement `remaining`.
    - If `remaining` == 0, the run is finished. If the FIFO is not empty, pop and load directly (same action as LOAD, no bubble). If the FIFO is empty, go to LOAD.
  - **EOF_WAIT:** `pixel_rgb` = 0. On `frame_start` → LOAD.
- **Underrun:** `pixel_en` while in LOAD with the FIFO empty.
  - The pixel is output as 0 (black).
  - `underrun` is set.
  - The pixel is lost; the run is not shifted.
- **Frame sync:**
  - `frame_start` in RUN or LOAD sets `sync_err`. The FSM continues unchanged and does not resync until the next EOF marker.
  - `frame_start` in the same cycle as an EOF pop is handled as EOF_WAIT + `frame_start` → LOAD.
- **Flags:** sticky, cleared only by reset.

## Timing
- **Reset values:**
  - Outputs: `shift_data` = 1, `pixel_rgb` = 0, `underrun` = 0, `overflow` = 0, `sync_err` = 0.
  - Internal: FSM = IDLE, FIFO empty.
- **Reset mid-run:** takes effect on the next edge. All state is discarded; the flash reader is not reset by this block.
- **Capture to FIFO:** 1 cycle. The entry is visible as non-empty on the cycle after the `instr_valid` rising edge.
- **`pixel_en` to next colour:** `pixel_rgb` and `remaining` are registered. The colour changes on the cycle after the `pixel_en` that completes a run.
- **LOAD with FIFO not empty:** 1 cycle to RUN.
- **`shift_data`:** derived from the count and capture state registered at the edge. The flash reader samples it on its word boundary.
- **Throughput:** the flash reader needs ≥6 cycles per word. Runs shorter than that, at one `pixel_en` per cycle, will underrun by design.

## Structure
- **Shared package `vga_player_pkg`:**
  - `RUN_W`, `COLOR_W`.
  - EOF marker constant `18'h3FFFF`.
  - Field-slice localparams.
  - Pixel FSM state encoding (IDLE, LOAD, RUN, EOF_WAIT).
- **Sub-module `instr_fifo2`:** a 2-entry, 18-bit register FIFO.
  - Ports: `push`, `pop`, `din`, `dout`, `count[1:0]`.
  - Full/empty are derived from `count`.

## Test plan
- **Reset:** after reset, drive `frame_start`. → FSM is in LOAD, `shift_data` = 1, `pixel_rgb` = 0.
- **Back-to-back runs:** preload instructions `{6'h30, 12'd2}` and `{6'h0C, 12'd0}`, then drive `pixel_en` continuously.
  - → `pixel_rgb` = 0x30 for exactly 3 `pixel_en`, then 0x0C for 1 `pixel_en`, with no bubble.
- **Held valid and pacing:** hold `instr_valid` high for 10 cycles.
  - → exactly one capture.
  - Fill to 2 entries → `shift_data` = 0.
  - Pop one entry → `shift_data` = 1 on the next cycle.
- **Underrun:** FIFO empty in LOAD, drive 3 `pixel_en`.
  - → `pixel_rgb` = 0 and `underrun` = 1, still set after further traffic.
- **EOF and frame sync:**
  - Feed the EOF marker → EOF_WAIT; `pixel_en` is ignored.
  - `frame_start` → LOAD. Check `sync_err` stays 0.
  - Then pulse `frame_start` mid-RUN → `sync_err` = 1, and the run continues.
- **Overflow:** with the FIFO full, drive a third `instr_valid` edge.
  - → `overflow` = 1 and FIFO contents unchanged.
